sega_pad_responder: RTL and testbench



---
 rtl/sega_pad_responder_if.sv | 22 ++
 rtl/sega_pad_responder.sv | 115 +++++++++++
 tb/tb_sega_pad_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sega_pad_responder_if.sv
// DB9 pad-side bundle: host-driven select and button state in, six pin levels and scan phase out.
interface sega_pad_responder_if;
    logic [11:0] buttons_i;
    logic        sel_i;
    logic        up_o;
    logic        down_o;
    logic        left_o;
    logic        right_o;
    logic        p6_o;
    logic        p9_o;
    logic [2:0]  phase_o;

    modport master (
        output buttons_i, sel_i,
        input  up_o, down_o, left_o, right_o, p6_o, p9_o, phase_o
    );

    modport slave (
        input  buttons_i, sel_i,
        output up_o, down_o, left_o, right_o, p6_o, p9_o, phase_o
    );
endinterface

// File: rtl/sega_pad_responder.sv
// Mega Drive pad emulator: counts select falls within a burst and drives the matching
// active-low button group onto the DB9 pins.
module sega_pad_responder #(
    parameter int TIMEOUT_CYCLES = 16500,
    parameter bit SIX_BUTTON     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    sega_pad_responder_if.slave   pad
);
    localparam int             IW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0]  IDLE_MAX = IW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0]  IDLE_ONE = IW'(1);
    localparam logic [2:0]     F_ZERO   = 3'd0;
    localparam logic [2:0]     F_ID     = 3'd3;
    localparam logic [2:0]     F_MAX    = 3'd4;

    logic          r_s1, r_s2, r_s3;
    logic [2:0]    r_f;
    logic [IW-1:0] r_idle;
    logic [5:0]    r_pins;

    logic          w_edge, w_fall, w_timeout, w_six_id, w_six_hi;
    logic [2:0]    w_f_base, w_f_next;
    logic [IW-1:0] w_idle_next;
    logic [5:0]    w_pins;
    logic [11:0]   w_b;

    assign w_b       = pad.buttons_i;
    assign w_edge    = r_s2 ^ r_s3;
    assign w_fall    = r_s3 & ~r_s2;
    assign w_timeout = (r_idle == IDLE_MAX);

    // Three-flop select synchronizer; s2/s3 form the edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= pad.sel_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Burst count: a timeout in the same cycle as a fall clears first, then the fall counts.
    always_comb begin
        w_f_base = w_timeout ? F_ZERO : r_f;
        if (w_fall) begin
            if (w_f_base == F_MAX) begin
                w_f_next = F_MAX;
            end else begin
                w_f_next = w_f_base + 3'd1;
            end
        end else begin
            w_f_next = w_f_base;
        end
    end

    // Idle counter clears on any select edge and saturates at the timeout value.
    always_comb begin
        if (w_edge) begin
            w_idle_next = '0;
        end else if (w_timeout) begin
            w_idle_next = IDLE_MAX;
        end else begin
            w_idle_next = r_idle + IDLE_ONE;
        end
    end

    assign w_six_id = SIX_BUTTON && (w_f_next == F_ID);
    assign w_six_hi = SIX_BUTTON && (w_f_next == F_MAX);

    // Group select from the select level and next count; pins order {up,down,left,right,p6,p9}.
    always_comb begin
        w_pins = 6'b111111;
        if (r_s2) begin
            if (w_six_id) begin
                w_pins = {~w_b[8], ~w_b[9], ~w_b[10], ~w_b[11], ~w_b[4], ~w_b[5]};
            end else begin
                w_pins = {~w_b[0], ~w_b[1], ~w_b[2], ~w_b[3], ~w_b[4], ~w_b[5]};
            end
        end else begin
            if (w_six_id) begin
                w_pins = {4'b0000, ~w_b[6], ~w_b[7]};
            end else if (w_six_hi) begin
                w_pins = {4'b1111, ~w_b[6], ~w_b[7]};
            end else begin
                w_pins = {~w_b[0], ~w_b[1], 2'b00, ~w_b[6], ~w_b[7]};
            end
        end
    end

    // Registered count, idle timer and pin levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_f    <= F_ZERO;
            r_idle <= IDLE_MAX;
            r_pins <= 6'b111111;
        end else begin
            r_f    <= w_f_next;
            r_idle <= w_idle_next;
            r_pins <= w_pins;
        end
    end

    assign pad.up_o    = r_pins[5];
    assign pad.down_o  = r_pins[4];
    assign pad.left_o  = r_pins[3];
    assign pad.right_o = r_pins[2];
    assign pad.p6_o    = r_pins[1];
    assign pad.p9_o    = r_pins[0];
    assign pad.phase_o = r_f;
endmodule

// File: tb/tb_sega_pad_responder.sv
// Drives a 6-button and a 3-button responder with the same select/button stream and
// checks both every cycle against a cycle-level model of the pad protocol.
module tb_sega_pad_responder;
    localparam int T = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tb_sel = 1'b1;
    logic [11:0] tb_btn = 12'h000;

    always #5 clk = ~clk;

    sega_pad_responder_if pad6 ();
    sega_pad_responder_if pad3 ();

    assign pad6.sel_i     = tb_sel;
    assign pad6.buttons_i = tb_btn;
    assign pad3.sel_i     = tb_sel;
    assign pad3.buttons_i = tb_btn;

    sega_pad_responder #(.TIMEOUT_CYCLES(T), .SIX_BUTTON(1'b1)) dut6 (
        .clk(clk), .reset(reset), .pad(pad6));
    sega_pad_responder #(.TIMEOUT_CYCLES(T), .SIX_BUTTON(1'b0)) dut3 (
        .clk(clk), .reset(reset), .pad(pad3));

    typedef struct packed {
        logic [5:0] pins6;
        logic [2:0] ph6;
        logic [5:0] pins3;
        logic [2:0] ph3;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Directed expectations handed from stimulus to the monitor
    int         dir_seq = 0;
    int         dir_seen = 0;
    string      dir_name = "";
    logic [5:0] dir_pins6, dir_pins3;
    logic [2:0] dir_ph6, dir_ph3;

    // Pin levels for a given select level, burst count and button word
    function automatic logic [5:0] grp(int lev, int f, bit six, logic [11:0] b);
        logic [5:0] r;
        if (lev != 0) begin
            if (six && f == 3) r = {~b[8], ~b[9], ~b[10], ~b[11], ~b[4], ~b[5]};
            else               r = {~b[0], ~b[1], ~b[2], ~b[3], ~b[4], ~b[5]};
        end else begin
            if (six && f == 3)      r = {4'b0000, ~b[6], ~b[7]};
            else if (six && f == 4) r = {4'b1111, ~b[6], ~b[7]};
            else                    r = {~b[0], ~b[1], 2'b00, ~b[6], ~b[7]};
        end
        return r;
    endfunction

    // Reference model: history of sampled select levels, falls since last timeout, idle age
    int hist[$];
    int fcnt = 0;
    int idle = T;
    always @(posedge clk) begin
        exp_t e;
        int   cur, prev;
        if (reset) begin
            hist.delete();
            hist.push_back(1); hist.push_back(1); hist.push_back(1);
            fcnt = 0;
            idle = T;
            e = {6'h3f, 3'd0, 6'h3f, 3'd0};
            q.push_back(e);
        end else if (hist.size() >= 3) begin
            cur  = hist[hist.size() - 2];
            prev = hist[hist.size() - 3];
            if (idle == T) fcnt = 0;
            if (prev == 1 && cur == 0) fcnt = (fcnt < 4) ? fcnt + 1 : 4;
            if (prev != cur) idle = 0;
            else if (idle < T) idle = idle + 1;
            e.pins6 = grp(cur, fcnt, 1'b1, tb_btn);
            e.pins3 = grp(cur, fcnt, 1'b0, tb_btn);
            e.ph6   = 3'(fcnt);
            e.ph3   = 3'(fcnt);
            q.push_back(e);
            hist.push_back(int'(tb_sel));
            if (hist.size() > 8) void'(hist.pop_front());
        end
    end

    task automatic cmp(string name, logic [5:0] gp, logic [2:0] gph,
                       logic [5:0] ep, logic [2:0] eph);
        n_vec++;
        if (gp !== ep || gph !== eph) begin
            n_bad++;
            $display("FAIL %s @%0t: got pins=%b phase=%0d, expected pins=%b phase=%0d",
                     name, $time, gp, gph, ep, eph);
        end
    endtask

    // Monitor: pop the model's expectation every cycle, plus any pending directed check
    always @(negedge clk) begin
        exp_t       e;
        logic [5:0] g6, g3;
        g6 = {pad6.up_o, pad6.down_o, pad6.left_o, pad6.right_o, pad6.p6_o, pad6.p9_o};
        g3 = {pad3.up_o, pad3.down_o, pad3.left_o, pad3.right_o, pad3.p6_o, pad3.p9_o};
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("model6", g6, pad6.phase_o, e.pins6, e.ph6);
            cmp("model3", g3, pad3.phase_o, e.pins3, e.ph3);
        end
        if (dir_seq != dir_seen) begin
            dir_seen = dir_seq;
            cmp({dir_name, "_six"},   g6, pad6.phase_o, dir_pins6, dir_ph6);
            cmp({dir_name, "_three"}, g3, pad3.phase_o, dir_pins3, dir_ph3);
        end
    end

    task automatic cyc(int n, bit rnd);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rnd && ($urandom_range(0, 3) == 0)) tb_btn = 12'($urandom);
        end
    endtask

    task automatic expect_dir(string name, logic [5:0] p6, logic [2:0] h6,
                              logic [5:0] p3, logic [2:0] h3);
        dir_name  = name;
        dir_pins6 = p6;
        dir_ph6   = h6;
        dir_pins3 = p3;
        dir_ph3   = h3;
        dir_seq++;
    endtask

    initial begin
        reset = 1'b1; tb_sel = 1'b1; tb_btn = 12'h000;
        cyc(3, 1'b0);
        reset = 1'b0;
        cyc(100, 1'b0);
        expect_dir("reset_hold", 6'h3f, 3'd0, 6'h3f, 3'd0);

        // First fall then rise with U|B|A
        tb_btn = 12'h051; tb_sel = 1'b0;
        cyc(10, 1'b0);
        expect_dir("first_low", 6'b010001, 3'd1, 6'b010001, 3'd1);
        tb_sel = 1'b1;
        cyc(10, 1'b0);
        expect_dir("first_high", 6'b011101, 3'd1, 6'b011101, 3'd1);

        // Long idle clears the burst count
        tb_btn = 12'h980;
        cyc(T + 5, 1'b0);
        expect_dir("timeout_idle", 6'h3f, 3'd0, 6'h3f, 3'd0);

        // Full burst with Z|Mode|Start
        for (int p = 1; p <= 4; p++) begin
            tb_sel = 1'b0;
            cyc(10, 1'b0);
            if (p == 3) expect_dir("f3_low", 6'b000010, 3'd3, 6'b110010, 3'd3);
            if (p == 4) expect_dir("f4_low", 6'b111110, 3'd4, 6'b110010, 3'd4);
            tb_sel = 1'b1;
            cyc(10, 1'b0);
            if (p == 3) expect_dir("f3_high", 6'b011011, 3'd3, 6'h3f, 3'd3);
        end

        // Hold just short of timeout: count stays saturated
        tb_sel = 1'b0; cyc(6, 1'b0);
        tb_sel = 1'b1; cyc(T, 1'b0);
        tb_sel = 1'b0; cyc(6, 1'b0);
        expect_dir("hold_short", 6'b111110, 3'd4, 6'b110010, 3'd4);
        // Timeout lands in the same cycle as the fall
        tb_sel = 1'b1; cyc(T + 1, 1'b0);
        tb_sel = 1'b0; cyc(6, 1'b0);
        expect_dir("timeout_with_fall", 6'b110010, 3'd1, 6'b110010, 3'd1);
        tb_sel = 1'b1; cyc(T + 2, 1'b0);
        tb_sel = 1'b0; cyc(6, 1'b0);

        // Randomised bursts, idle gaps near the timeout, occasional resets
        for (int k = 0; k < 300; k++) begin
            tb_sel = ~tb_sel;
            if (tb_sel && ($urandom_range(0, 9) == 0))
                cyc(T - 3 + $urandom_range(0, 6), 1'b1);
            else
                cyc($urandom_range(4, 12), 1'b1);
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                cyc($urandom_range(1, 3), 1'b1);
                reset = 1'b0;
            end
        end

        // Reset while sitting at f=3 with select low
        tb_sel = 1'b1; tb_btn = 12'h980;
        cyc(T + 5, 1'b0);
        for (int p = 0; p < 3; p++) begin
            tb_sel = 1'b0; cyc(6, 1'b0);
            if (p < 2) begin
                tb_sel = 1'b1; cyc(6, 1'b0);
            end
        end
        expect_dir("pre_reset_f3", 6'b000010, 3'd3, 6'b110010, 3'd3);
        reset = 1'b1;
        cyc(1, 1'b0);
        reset = 1'b0;
        expect_dir("reset_mid_burst", 6'h3f, 3'd0, 6'h3f, 3'd0);
        cyc(20, 1'b0);

        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
